// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI widths, slave FSM states and frame-size helpers
package spi_pkg;
    localparam int DWIDTH       = 32;
    localparam int AWIDTH       = 12;
    localparam int S_ADDR_WIDTH = 2;
    localparam int CTRL_NBITS   = AWIDTH + 3;

    typedef enum logic [2:0] {IDLE, CTRL, WDATA, WAIT, RDATA, SKIP} spi_slv_state_t;

    function automatic logic [5:0] size_to_nbits(input logic [1:0] size);
        return size == 2'd0 ? 6'd8 : size == 2'd1 ? 6'd16 : 6'd32;
    endfunction

    function automatic logic [DWIDTH/8-1:0] size_to_be(input logic [1:0] size);
        return size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : 4'b1111;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with single-cycle rise/fall pulses
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= SYNC_STAGES'({sync_q, d_i});
            prev_q <= q_o;
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave decoding write/read frames into one-cycle memory accesses
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_NBITS  = 2,
    parameter int SLV_IDX     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  ss_n,
    output logic                  miso,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH-1:0]     mem_wdata,
    output logic [DWIDTH/8-1:0]   mem_be,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DWIDTH-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  err_size
);
    // SLV_IDX only labels the instance
    if (SLV_IDX < 0) begin : g_bad_slv_idx
    end

    spi_slv_state_t           state_q, state_d;
    logic [5:0]               cnt_q, cnt_d, cnt_inc, nbits;
    logic [DWIDTH-1:0]        rx_q, rx_d, rx_sh, tx_q, tx_d;
    logic [1:0]               mode_q, mode_d, size_q, size_d;
    logic [AWIDTH-1:0]        addr_q, addr_d;
    logic [DWIDTH-1:0]        wdata_q, wdata_d;
    logic [DWIDTH/8-1:0]      be_q, be_d;
    logic                     we_q, we_d, re_q, re_d, err_q, err_d;
    logic                     miso_en_q, miso_en_d, rcap_q, rcap_d;
    logic [SYNC_STAGES-1:0]   mosi_q;
    logic                     sck_rise, sck_fall, ss_rise, ss_fall, mosi_s, samp, chg;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .d_i(sck), .q_o(), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .d_i(ss_n), .q_o(), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    // Same depth as sck so mosi lines up with the detected sck edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_q <= '0;
        else        mosi_q <= SYNC_STAGES'({mosi_q, mosi});
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign samp    = (mode_q[1] == mode_q[0]) ? sck_rise : sck_fall;
    assign chg     = (mode_q[1] == mode_q[0]) ? sck_fall : sck_rise;
    assign cnt_inc = cnt_q + 6'd1;
    assign rx_sh   = {rx_q[DWIDTH-2:0], mosi_s};
    assign nbits   = size_to_nbits(size_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = rcap_q ? mem_rdata << (6'(DWIDTH) - nbits) : tx_q;
        mode_d    = mode_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        err_d     = 1'b0;
        miso_en_d = miso_en_q;
        rcap_d    = re_q;
        case (state_q)
            IDLE: begin
                mode_d = mode;
                if (ss_fall) begin
                    state_d = CTRL;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end
            CTRL: if (samp) begin
                rx_d  = rx_sh;
                cnt_d = cnt_inc;
                if (cnt_inc == 6'(CTRL_NBITS)) begin
                    cnt_d  = '0;
                    size_d = rx_sh[AWIDTH+1:AWIDTH];
                    if (rx_sh[AWIDTH+1:AWIDTH] == 2'd3) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end else begin
                        addr_d  = rx_sh[AWIDTH-1:0];
                        rx_d    = '0;
                        re_d    = ~rx_sh[AWIDTH+2];
                        state_d = rx_sh[AWIDTH+2] ? WDATA : WAIT;
                    end
                end
            end
            WDATA: if (samp) begin
                rx_d  = rx_sh;
                cnt_d = cnt_inc;
                if (cnt_inc == nbits) begin
                    we_d    = 1'b1;
                    wdata_d = rx_sh;
                    be_d    = size_to_be(size_q);
                    state_d = SKIP;
                end
            end
            WAIT: if (samp) begin
                cnt_d = cnt_inc;
                if (cnt_inc == 6'(WAIT_NBITS)) begin
                    cnt_d   = '0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                // First change edge only enables the output; later ones shift
                if (chg) begin
                    miso_en_d = 1'b1;
                    if (miso_en_q) tx_d = tx_q << 1;
                end
                if (samp && miso_en_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == nbits) begin
                        miso_en_d = 1'b0;
                        state_d   = SKIP;
                    end
                end
            end
            default: ;
        endcase
        if (ss_rise) begin
            state_d   = IDLE;
            miso_en_d = 1'b0;
            we_d      = 1'b0;
            re_d      = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            mode_q    <= '0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            err_q     <= 1'b0;
            miso_en_q <= 1'b0;
            rcap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            mode_q    <= mode_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            re_q      <= re_d;
            err_q     <= err_d;
            miso_en_q <= miso_en_d;
            rcap_q    <= rcap_d;
        end
    end

    assign miso      = miso_en_q ? tx_q[DWIDTH-1] : 1'bz;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign err_size  = err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master frames with a scoreboard-driven memory-port monitor
module tb_spi_slave;
    import spi_pkg::*;

    localparam int H    = 8;
    localparam int SYNC = 2;
    localparam int WT   = 2;

    logic                clk = 1'b0, rst_n = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic                sck = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    wire                 miso;
    logic [AWIDTH-1:0]   mem_addr;
    logic [DWIDTH-1:0]   mem_wdata;
    logic [DWIDTH-1:0]   mem_rdata = '0;
    logic [DWIDTH-1:0]   rd_word = '0;
    logic [DWIDTH/8-1:0] mem_be;
    logic                mem_we, mem_re, busy, err_size;
    wire                 miso_z = (miso === 1'bz);

    typedef enum int {K_WR, K_RD, K_ERR, K_CAP} kind_t;
    typedef struct {
        kind_t       k;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } txn_t;

    txn_t        sb[$];
    int          tests = 0, fails = 0, z_bad = 0;
    bit          expect_z = 1'b0;
    logic [31:0] cap_data = '0;
    event        cap_ev;

    spi_slave #(.SYNC_STAGES(SYNC), .WAIT_NBITS(WT), .SLV_IDX(0)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sck(sck), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy),
        .err_size(err_size)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem_re ? rd_word : 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input kind_t k, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        txn_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_%s: got a transaction, expected none", k.name());
            return;
        end
        e = sb.pop_front();
        chk("sb_kind", 64'(k), 64'(e.k));
        if (k == K_WR || k == K_RD) chk("sb_addr", 64'(a), 64'(e.a));
        if (k == K_WR || k == K_CAP) chk("sb_data", 64'(d), 64'(e.d));
        if (k == K_WR) chk("sb_be", 64'(be), 64'(e.be));
    endtask

    always @(negedge clk) begin
        if (expect_z && !miso_z) z_bad++;
        if (mem_we) pop_cmp(K_WR, mem_addr, mem_wdata, mem_be);
        if (mem_re) pop_cmp(K_RD, mem_addr, 32'h0, 4'h0);
        if (err_size) pop_cmp(K_ERR, 12'h0, 32'h0, 4'h0);
    end

    always @(cap_ev) pop_cmp(K_CAP, 12'h0, cap_data, 4'h0);

    function automatic logic bitval(input logic [63:0] ob, input int n, input int i);
        return (i < n) ? ob[n-1-i] : 1'b0;
    endfunction

    task automatic hp();
        repeat (H) @(negedge clk);
    endtask

    task automatic push(input kind_t k, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        txn_t t;
        t.k = k; t.a = a; t.d = d; t.be = be;
        sb.push_back(t);
    endtask

    // Master: n_per sck periods, the first n_out carry ob MSB-first, the last n_in capture miso
    task automatic xfer(input logic [1:0] m, input logic [63:0] ob, input int n_out, input int n_per,
                        input int n_in, input int stop_at, input bit keep_ss);
        logic [31:0] rx = '0;
        int first_in = n_per - n_in;
        mode = m;
        sck  = m[1];
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        if (!m[0]) mosi = bitval(ob, n_out, 0);
        ss_n = 1'b0;
        hp();
        chk("busy_in_frame", 64'(busy), 64'd1);
        for (int i = 0; i < n_per; i++) begin
            if (i == stop_at) break;
            if (m[0]) mosi = bitval(ob, n_out, i);
            else if (i >= first_in) rx = {rx[30:0], miso};
            sck = ~sck;
            hp();
            if (!m[0]) mosi = bitval(ob, n_out, i + 1);
            else if (i >= first_in) rx = {rx[30:0], miso};
            sck = ~sck;
            hp();
        end
        if (!keep_ss) begin
            ss_n = 1'b1;
            repeat (SYNC + 2) @(negedge clk);
            chk("busy_after_ss", 64'(busy), 64'd0);
            repeat (4) @(negedge clk);
        end
        if (n_in > 0 && stop_at >= n_per) begin
            cap_data = rx;
            ->cap_ev;
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [1:0] m, input logic [1:0] sz, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] be);
        int nb = 8 << sz;
        int z0 = z_bad;
        push(K_WR, a, d, be);
        expect_z = 1'b1;
        xfer(m, (64'({1'b1, sz, a}) << nb) | 64'(d), 15 + nb, 15 + nb, 0, 1000, 1'b0);
        expect_z = 1'b0;
        chk("miso_z_write", 64'(z_bad - z0), 64'd0);
    endtask

    task automatic rd(input logic [1:0] m, input logic [1:0] sz, input logic [11:0] a,
                      input logic [31:0] word, input logic [31:0] exp_cap);
        int nb = 8 << sz;
        rd_word = word;
        push(K_RD, a, 32'h0, 4'h0);
        push(K_CAP, 12'h0, exp_cap, 4'h0);
        xfer(m, 64'({1'b0, sz, a}), 15, 15 + WT + nb, nb, 1000, 1'b0);
        chk("miso_z_after_read", 64'(miso_z), 64'd1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_we"},    64'(mem_we),    64'd0);
        chk({p, "_re"},    64'(mem_re),    64'd0);
        chk({p, "_busy"},  64'(busy),      64'd0);
        chk({p, "_err"},   64'(err_size),  64'd0);
        chk({p, "_addr"},  64'(mem_addr),  64'd0);
        chk({p, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({p, "_be"},    64'(mem_be),    64'd0);
        chk({p, "_miso_z"}, 64'(miso_z),   64'd1);
    endtask

    initial begin
        int z0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        wr(2'b00, 2'd2, 12'h0A5, 32'hDEADBEEF, 4'b1111);
        wr(2'b11, 2'd0, 12'hFFF, 32'h0000003C, 4'b0001);
        wr(2'b01, 2'd1, 12'h456, 32'h00001234, 4'b0011);
        rd(2'b00, 2'd1, 12'h010, 32'h0000BEEF, 32'h0000BEEF);
        rd(2'b10, 2'd0, 12'h123, 32'h123456A7, 32'h000000A7);

        // Abort after 5 of 16 write data bits, then a clean frame
        xfer(2'b00, (64'({1'b1, 2'd1, 12'h021}) << 16) | 64'h1234, 31, 31, 0, 20, 1'b0);
        wr(2'b00, 2'd1, 12'h021, 32'h0000A5C3, 4'b0011);

        z0 = z_bad;
        push(K_ERR, 12'h0, 32'h0, 4'h0);
        expect_z = 1'b1;
        xfer(2'b00, 64'({1'b0, 2'd3, 12'h077}), 15, 23, 0, 1000, 1'b0);
        expect_z = 1'b0;
        chk("miso_z_err", 64'(z_bad - z0), 64'd0);

        // Reset while miso is being driven
        rd_word = 32'hCAFEF00D;
        push(K_RD, 12'h0C0, 32'h0, 4'h0);
        xfer(2'b00, 64'({1'b0, 2'd2, 12'h0C0}), 15, 15 + WT + 32, 32, 27, 1'b1);
        chk("miso_driven_rdata", 64'(miso_z), 64'd0);
        rst_n = 1'b0;
        #1;
        chk_reset("midframe_reset");
        ss_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        wr(2'b00, 2'd0, 12'h3AB, 32'h00000081, 4'b0001);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
